// File: rtl/mfp_usart_tx_if.sv
// Register-side signal bundle of the MFP68901 USART transmitter:
// UCR/TSR/UDR access from the CPU plus status and interrupt requests.
interface mfp_usart_tx_if;
  logic [7:0] UCR_I;
  logic       TE;
  logic       BRK;
  logic       DAT_WE;
  logic [7:0] DAT_I;
  logic       STAT_RD;
  logic       BUF_EMPTY;
  logic       UNDERRUN;
  logic       END_O;
  logic       IRQ_EMPTY;
  logic       IRQ_ERR;

  modport master (
    output UCR_I, TE, BRK, DAT_WE, DAT_I, STAT_RD,
    input  BUF_EMPTY, UNDERRUN, END_O, IRQ_EMPTY, IRQ_ERR
  );

  modport slave (
    input  UCR_I, TE, BRK, DAT_WE, DAT_I, STAT_RD,
    output BUF_EMPTY, UNDERRUN, END_O, IRQ_EMPTY, IRQ_ERR
  );
endinterface

// File: rtl/mfp_usart_tx.sv
// MFP68901 USART transmitter: UDR holding register, async frame serialiser
// clocked by timer-D TC pulses, underrun/break handling and TX interrupts.
module mfp_usart_tx #(
  parameter int DIV_FACTOR = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TC_PULSE,
  output logic SO,
  mfp_usart_tx_if.slave bus
);

  localparam int CW = $clog2(2 * DIV_FACTOR + 1);
  localparam logic [CW-1:0] LEN_1P  = CW'(DIV_FACTOR);
  localparam logic [CW-1:0] LEN_15P = CW'((3 * DIV_FACTOR + 1) / 2);
  localparam logic [CW-1:0] LEN_2P  = CW'(2 * DIV_FACTOR);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      hold_reg, hold_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:2]      cfg_reg, cfg_next;
  logic [CW-1:0]   tick_reg, tick_next;
  logic [2:0]      bit_reg, bit_next;
  logic            par_reg, par_next;
  logic            so_reg, so_next;
  logic            buf_empty_reg, buf_empty_next;
  logic            underrun_reg, underrun_next;
  logic            irq_empty_reg, irq_err_reg;

  logic            load, set_ur, tick_done;
  logic [CW-1:0]   tick_inc, bit_len, stop_len, cur_len;
  logic [2:0]      cfg_last, ld_last;
  logic [7:0]      ld_mask;
  logic            ucr_unused;

  assign ucr_unused = bus.UCR_I[0];

  // Data-bit mask for the character being loaded, from the live word length
  assign ld_last = 3'd7 - {1'b0, bus.UCR_I[6:5]};
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign ld_mask[gi] = (3'(gi) <= ld_last);
    end
  endgenerate

  assign cfg_last = 3'd7 - {1'b0, cfg_reg[6:5]};
  assign bit_len  = cfg_reg[7] ? LEN_1P : CW'(1);
  assign cur_len  = (state_reg == STOP) ? stop_len : bit_len;
  assign tick_inc = tick_reg + CW'(1);
  assign tick_done = TC_PULSE && (tick_inc == cur_len);

  // Sync mode (00) is sent as one stop bit; 1.5 stop rounds up to 2 ticks in /1
  always_comb begin
    stop_len = bit_len;
    case (cfg_reg[4:3])
      2'b10:   stop_len = cfg_reg[7] ? LEN_15P : CW'(2);
      2'b11:   stop_len = cfg_reg[7] ? LEN_2P : CW'(2);
      default: stop_len = bit_len;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = bus.DAT_WE ? bus.DAT_I : hold_reg;
    shift_next = shift_reg;
    cfg_next   = cfg_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    par_next   = par_reg;
    so_next    = so_reg;
    load       = 1'b0;
    set_ur     = 1'b0;

    if ((state_reg inside {START, DATA, PARITY, STOP}) && TC_PULSE)
      tick_next = tick_done ? '0 : tick_inc;

    case (state_reg)
      IDLE: begin
        so_next = 1'b1;
        if (bus.TE && bus.BRK) begin
          state_next = BREAK;
          so_next    = 1'b0;
        end else if (bus.TE && !buf_empty_reg) begin
          load = 1'b1;
        end
      end
      START: begin
        if (tick_done) begin
          state_next = DATA;
          so_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = 3'd0;
        end
      end
      DATA: begin
        if (tick_done) begin
          if (bit_reg == cfg_last) begin
            if (cfg_reg[2]) begin
              state_next = PARITY;
              so_next    = par_reg;
            end else begin
              state_next = STOP;
              so_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 3'd1;
            so_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end
      end
      PARITY: begin
        if (tick_done) begin
          state_next = STOP;
          so_next    = 1'b1;
        end
      end
      STOP: begin
        if (tick_done) begin
          if (bus.TE && !bus.BRK && !buf_empty_reg) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            set_ur     = bus.TE && buf_empty_reg;
          end
        end
      end
      BREAK: begin
        so_next = 1'b0;
        if (!(bus.TE && bus.BRK)) begin
          state_next = IDLE;
          so_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame load: shifter takes the pre-write holding value, parity precomputed
    if (load) begin
      state_next = START;
      so_next    = 1'b0;
      tick_next  = '0;
      cfg_next   = bus.UCR_I[7:2];
      shift_next = hold_reg;
      par_next   = (^(hold_reg & ld_mask)) ^ ~bus.UCR_I[1];
    end

    buf_empty_next = bus.DAT_WE ? 1'b0 : (load ? 1'b1 : buf_empty_reg);
    underrun_next  = set_ur ? 1'b1 : (bus.STAT_RD ? 1'b0 : underrun_reg);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      shift_reg     <= '0;
      cfg_reg       <= '0;
      tick_reg      <= '0;
      bit_reg       <= '0;
      par_reg       <= 1'b0;
      so_reg        <= 1'b1;
      buf_empty_reg <= 1'b1;
      underrun_reg  <= 1'b0;
      irq_empty_reg <= 1'b0;
      irq_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      shift_reg     <= shift_next;
      cfg_reg       <= cfg_next;
      tick_reg      <= tick_next;
      bit_reg       <= bit_next;
      par_reg       <= par_next;
      so_reg        <= so_next;
      buf_empty_reg <= buf_empty_next;
      underrun_reg  <= underrun_next;
      irq_empty_reg <= load;
      irq_err_reg   <= set_ur;
    end
  end

  assign SO            = so_reg;
  assign bus.BUF_EMPTY = buf_empty_reg;
  assign bus.UNDERRUN  = underrun_reg;
  assign bus.IRQ_EMPTY = irq_empty_reg;
  assign bus.IRQ_ERR   = irq_err_reg;
  assign bus.END_O     = ~bus.TE && (state_reg == IDLE);

endmodule
